inv_sub_bytes_seq: RTL

- Sequential AES InvSubBytes unit for the decryption round datapath.
- Applies the FIPS-197 inverse S-box to all 16 bytes of a 128-bit state.
- Processes LANES bytes per cycle, sharing LANES inverse S-box instances across the state.
- Valid/ready handshakes on both sides; sits between InvShiftRows and AddRoundKey in the decrypt round.

---
 rtl/inv_sub_bytes_seq.sv | 116 +++++++++++
 1 files changed

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: AES InvSubBytes over a 128-bit state, LANES bytes/cycle.
// Ports: clk, rst (async high); in_valid/in_ready/in_state; out_valid/out_ready/out_state; busy.
module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N = 16 / LANES;
  localparam logic [3:0] LN = 4'(LANES);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
        LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [0:255][7:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV[b];
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic [3:0]   idx;
  logic [127:0] sbuf, run_buf;
  logic         last;

  assign last = (cnt == 4'(N - 1));

  // Byte i lives at bit offset 8*(15-i); for a 4-bit index 15-i == ~i.
  always_comb begin
    run_buf = sbuf;
    idx = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = cnt * LN + 4'(l);
      run_buf[{~idx, 3'b000} +: 8] = inv_sbox(sbuf[{~idx, 3'b000} +: 8]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbuf      <= '0;
      cnt       <= '0;
      out_state <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sbuf <= in_state;
            cnt  <= '0;
          end
        end
        RUN: begin
          sbuf <= run_buf;
          if (last) begin
            cnt       <= '0;
            out_state <= run_buf;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
